// File: rtl/bnn_pkg.sv
// Shared definitions for the binarised feature-map buffer: widths, map sizes,
// replay word constants and FSM state encoding.
package bnn_pkg;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 144;
  localparam int unsigned N0    = 144;
  localparam int unsigned N1    = 16;
  localparam int unsigned AW    = 8;

  localparam logic [DW-1:0] PLUS1  = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] MINUS1 = {DW{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StFull,
    StDrain
  } state_e;

endpackage

// File: rtl/bnn_bitmem.sv
// Depth x 1 bit memory: one write port, one registered read port.
// Contents are not reset so the array can map onto distributed RAM.
module bnn_bitmem #(
  parameter int unsigned Depth = 144,
  parameter int unsigned Aw    = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [Aw-1:0] i_waddr,
  input  logic          i_wdata,
  input  logic [Aw-1:0] i_raddr,
  output logic          o_rdata
);

  logic r_mem [Depth];
  logic r_rdata;

  // The prefetch address runs one past the last entry at the end of a pass.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= (i_raddr < Aw'(Depth)) ? r_mem[i_raddr] : 1'b0;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bnn_fmap_buffer.sv
// Captures conv results as a 1-bit-per-pixel map (result >= threshold) and
// replays it as +1/-1 words, once per rd_start, under downstream backpressure.
module bnn_fmap_buffer
  import bnn_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          layer_sel,
  input  logic [DW-1:0] thresh,
  input  logic          in_valid,
  input  logic          in_last,
  input  logic [DW-1:0] in_data,
  input  logic          rd_start,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          full,
  output logic          err
);

  state_e        r_state;
  logic [AW-1:0] r_wr_cnt;
  logic [AW-1:0] r_rd_cnt;
  logic [AW-1:0] r_n;
  logic          r_err;

  logic          w_bit;
  logic          w_we;
  logic          w_start;
  logic          w_xfer;
  logic          w_rd_last;
  logic          w_rd_bit;
  logic [AW-1:0] w_raddr;
  logic [AW-1:0] w_cnt_next;
  logic [AW-1:0] w_n_exp;

  assign w_bit   = $signed(in_data) >= $signed(thresh);
  assign w_we    = in_valid && ((r_state == StIdle) ||
                                ((r_state == StFill) && (r_wr_cnt != AW'(DEPTH))));
  assign w_start = (r_state == StFull) && rd_start;
  assign w_xfer  = (r_state == StDrain) && out_ready;
  assign w_rd_last  = (r_rd_cnt == r_n - AW'(1));
  assign w_cnt_next = r_wr_cnt + AW'(w_we);
  // N is latched on the first word, so compare against the live selection in IDLE.
  assign w_n_exp    = (r_state == StIdle) ? (layer_sel ? AW'(N1) : AW'(N0)) : r_n;

  // Prefetch the word that will be on the output next cycle.
  always_comb begin
    w_raddr = r_rd_cnt;
    if (w_start) begin
      w_raddr = '0;
    end else if (w_xfer) begin
      w_raddr = r_rd_cnt + AW'(1);
    end
  end

  bnn_bitmem #(
    .Depth(DEPTH),
    .Aw   (AW)
  ) u_bitmem (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(r_wr_cnt),
    .i_wdata(w_bit),
    .i_raddr(w_raddr),
    .o_rdata(w_rd_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_n      <= '0;
      r_err    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StFill: begin
          if (in_valid) begin
            r_wr_cnt <= w_cnt_next;
            if (r_state == StIdle) begin
              r_n <= w_n_exp;
            end
            if (!w_we) begin
              r_err <= 1'b1;
            end
            if (in_last) begin
              r_state <= StFull;
              r_n     <= w_cnt_next;
              if (w_cnt_next != w_n_exp) begin
                r_err <= 1'b1;
              end
            end else begin
              r_state <= StFill;
            end
          end
        end
        StFull: begin
          if (in_valid) begin
            r_err <= 1'b1;
          end
          if (rd_start) begin
            r_state  <= StDrain;
            r_rd_cnt <= '0;
          end
        end
        StDrain: begin
          if (in_valid) begin
            r_err <= 1'b1;
          end
          if (out_ready) begin
            if (w_rd_last) begin
              r_state  <= StFull;
              r_rd_cnt <= '0;
            end else begin
              r_rd_cnt <= r_rd_cnt + AW'(1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign out_valid = (r_state == StDrain);
  assign out_last  = out_valid && w_rd_last;
  assign out_data  = out_valid ? (w_rd_bit ? PLUS1 : MINUS1) : '0;
  assign full      = (r_state == StFull);
  assign err       = r_err;

endmodule

// File: tb/tb_bnn_fmap_buffer.sv
// Randomised bench for bnn_fmap_buffer; the expected map is a queue of bits
// derived from the threshold rule and replayed as +1/-1 words.
module tb_bnn_fmap_buffer;
  import bnn_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          layer_sel;
  logic [DW-1:0] thresh;
  logic          in_valid;
  logic          in_last;
  logic [DW-1:0] in_data;
  logic          rd_start;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          full;
  logic          err;

  always #5 clk = ~clk;

  bnn_fmap_buffer dut (
    .clk      (clk),
    .rst      (rst),
    .layer_sel(layer_sel),
    .thresh   (thresh),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_data  (in_data),
    .rd_start (rd_start),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .full     (full),
    .err      (err)
  );

  int n_vec = 0;
  int n_bad = 0;

  bit            model_bits[$];
  logic [DW-1:0] stim[$];
  logic [DW-1:0] got_w[$];
  bit            got_l[$];
  logic [DW-1:0] pass_ref[$];
  int            hold_viol;
  int            cycles_used;
  bit            first_valid;

  // Expected {last, word} for replay position i of an n-word map.
  function automatic logic [DW:0] exp_entry(int i, int n);
    logic [DW-1:0] w;
    w = model_bits[i] ? DW'(1) : DW'(-1);
    return {(i == n - 1), w};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    rd_start = 1'b0; out_ready = 1'b0; layer_sel = 1'b0; thresh = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic rand_stim(input int n, input logic [DW-1:0] thr);
    int off;
    stim.delete();
    for (int i = 0; i < n; i++) begin
      off = int'($urandom_range(0, 6)) - 3;
      if ($urandom_range(0, 3) == 0) stim.push_back($urandom);
      else stim.push_back(thr + DW'(off));
    end
  endtask

  // Streams stim[] into the DUT, flagging the final word as last.
  task automatic fill(input bit lsel, input logic [DW-1:0] thr);
    model_bits.delete();
    layer_sel = lsel;
    thresh = thr;
    foreach (stim[i]) begin
      in_valid = 1'b1;
      in_data = stim[i];
      in_last = (i == stim.size() - 1);
      model_bits.push_back($signed(stim[i]) >= $signed(thr));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One replay pass; mode 0 = ready high, 1 = toggling, 2 = random ready.
  task automatic replay(input int mode, input bit imm, input int max_cyc);
    logic [DW-1:0] prev_data;
    bit prev_pend;
    bit done;
    int cyc;
    got_w.delete(); got_l.delete();
    hold_viol = 0; prev_pend = 0; done = 0; cyc = 0; prev_data = '0; first_valid = 0;
    if (!imm) begin
      @(posedge clk);
      #1;
    end
    rd_start = 1'b1;
    @(posedge clk);
    #1 rd_start = 1'b0;
    while (!done && cyc < max_cyc) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ((cyc % 2) == 1);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (cyc == 0) first_valid = (out_valid === 1'b1);
      if (prev_pend && (out_valid !== 1'b1 || out_data !== prev_data)) hold_viol++;
      prev_pend = (out_valid === 1'b1) && !out_ready;
      prev_data = out_data;
      if (out_valid === 1'b1 && out_ready) begin
        got_w.push_back(out_data);
        got_l.push_back(out_last === 1'b1);
        done = (out_last === 1'b1);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    cycles_used = cyc;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_vec++;
    if ({out_valid, out_last, full, err} !== 4'b0000 || out_data !== '0) begin
      n_bad++;
      $display("FAIL reset: got v/l/f/e=%b%b%b%b data=%h, need 0000 data=0",
               out_valid, out_last, full, err, out_data);
    end
    do_reset();
    @(negedge clk);
    n_vec++;
    if ({out_valid, full, err} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_hold: got v/f/e=%b%b%b need 000", out_valid, full, err);
    end
  endtask

  task automatic test_layer0();
    do_reset();
    stim.delete();
    for (int i = 0; i < 144; i++) stim.push_back((i % 2 == 0) ? DW'(5) : DW'(-5));
    fill(1'b0, '0);
    n_vec++;
    if (full !== 1'b1 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL layer0_fill: got full=%b err=%b need full=1 err=0", full, err);
    end
    replay(0, 1'b0, 400);
    n_vec++;
    if (!first_valid || got_w.size() != 144 || cycles_used != 144) begin
      n_bad++;
      $display("FAIL layer0_count: got first=%b words=%0d cycles=%0d need 1/144/144",
               first_valid, got_w.size(), cycles_used);
    end
    for (int i = 0; i < got_w.size() && i < 144; i++) begin
      n_vec++;
      if ({got_l[i], got_w[i]} !== exp_entry(i, 144)) begin
        n_bad++;
        $display("FAIL layer0_word%0d: got %h need %h", i, {got_l[i], got_w[i]}, exp_entry(i, 144));
      end
    end
    n_vec++;
    if (out_valid !== 1'b0 || full !== 1'b1) begin
      n_bad++;
      $display("FAIL layer0_end: got valid=%b full=%b need 0/1", out_valid, full);
    end
  endtask

  task automatic test_layer1();
    do_reset();
    rd_start = 1'b1;
    @(posedge clk);
    #1 rd_start = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_rd_start: got valid=%b need 0", out_valid);
    end
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(DW'(99 + i));
    fill(1'b1, DW'(100));
    n_vec++;
    if (full !== 1'b1 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL layer1_fill: got full=%b err=%b need 1/0", full, err);
    end
    replay(0, 1'b0, 100);
    n_vec++;
    if (got_w.size() != 16) begin
      n_bad++;
      $display("FAIL layer1_count: got %0d need 16", got_w.size());
    end
    for (int i = 0; i < got_w.size() && i < 16; i++) begin
      n_vec++;
      if ({got_l[i], got_w[i]} !== exp_entry(i, 16)) begin
        n_bad++;
        $display("FAIL layer1_word%0d: got %h need %h", i, {got_l[i], got_w[i]}, exp_entry(i, 16));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] thr;
    do_reset();
    thr = DW'(int'($urandom_range(0, 400)) - 200);
    rand_stim(144, thr);
    fill(1'b0, thr);
    for (int m = 1; m <= 2; m++) begin
      replay(m, 1'b0, 2000);
      n_vec++;
      if (hold_viol != 0 || got_w.size() != 144) begin
        n_bad++;
        $display("FAIL bp_mode%0d: got holdviol=%0d words=%0d need 0/144", m, hold_viol,
                 got_w.size());
      end
      for (int i = 0; i < got_w.size() && i < 144; i++) begin
        n_vec++;
        if ({got_l[i], got_w[i]} !== exp_entry(i, 144)) begin
          n_bad++;
          $display("FAIL bp_mode%0d_word%0d: got %h need %h", m, i, {got_l[i], got_w[i]},
                   exp_entry(i, 144));
        end
      end
    end
  endtask

  task automatic test_early_last();
    logic [DW-1:0] thr;
    do_reset();
    thr = $urandom;
    rand_stim(11, thr);
    fill(1'b0, thr);
    n_vec++;
    if (full !== 1'b1 || err !== 1'b1) begin
      n_bad++;
      $display("FAIL early_last_flags: got full=%b err=%b need 1/1", full, err);
    end
    replay(2, 1'b0, 200);
    n_vec++;
    if (got_w.size() != 11) begin
      n_bad++;
      $display("FAIL early_last_count: got %0d need 11", got_w.size());
    end
    for (int i = 0; i < got_w.size() && i < 11; i++) begin
      n_vec++;
      if ({got_l[i], got_w[i]} !== exp_entry(i, 11)) begin
        n_bad++;
        $display("FAIL early_word%0d: got %h need %h", i, {got_l[i], got_w[i]}, exp_entry(i, 11));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] thr;
    do_reset();
    thr = DW'(int'($urandom_range(0, 100)) - 50);
    rand_stim(144, thr);
    fill(1'b0, thr);
    pass_ref.delete();
    for (int i = 0; i < 144; i++) pass_ref.push_back(exp_entry(i, 144) & {1'b0, {DW{1'b1}}});
    for (int p = 0; p < 3; p++) begin
      replay(0, (p != 0), 400);
      n_vec++;
      if (!first_valid || got_w.size() != 144 || got_l[got_l.size()-1] !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_pass%0d: got first=%b words=%0d need 1/144 ending last", p,
                 first_valid, got_w.size());
      end
      for (int i = 0; i < got_w.size() && i < 144; i++) begin
        n_vec++;
        if (got_w[i] !== pass_ref[i]) begin
          n_bad++;
          $display("FAIL b2b_pass%0d_word%0d: got %h need %h", p, i, got_w[i], pass_ref[i]);
        end
      end
    end
    n_vec++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_err_clean: got err=%b need 0", err);
    end
    in_valid = 1'b1;
    in_data = ~stim[0];
    @(posedge clk);
    #1 in_valid = 1'b0;
    n_vec++;
    if (err !== 1'b1 || full !== 1'b1) begin
      n_bad++;
      $display("FAIL full_in_valid: got err=%b full=%b need 1/1", err, full);
    end
    replay(0, 1'b0, 400);
    for (int i = 0; i < got_w.size() && i < 144; i++) begin
      n_vec++;
      if (got_w[i] !== pass_ref[i]) begin
        n_bad++;
        $display("FAIL map_unchanged_word%0d: got %h need %h", i, got_w[i], pass_ref[i]);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [DW-1:0] thr;
    do_reset();
    thr = DW'(int'($urandom_range(0, 20)) - 10);
    rand_stim(144, thr);
    fill(1'b0, thr);
    @(posedge clk);
    #1 rd_start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 rd_start = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== exp_entry(50, 144) >> 0 & {1'b0, {DW{1'b1}}}) begin
      n_bad++;
      $display("FAIL mid_drain_word50: got valid=%b data=%h need 1/%h", out_valid, out_data,
               exp_entry(50, 144) & {1'b0, {DW{1'b1}}});
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({out_valid, out_last, full, err} !== 4'b0000 || out_data !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got v/l/f/e=%b%b%b%b data=%h need 0000/0",
               out_valid, out_last, full, err, out_data);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b0;
    thr = $urandom;
    rand_stim(16, thr);
    fill(1'b1, thr);
    n_vec++;
    if (full !== 1'b1 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL refill: got full=%b err=%b need 1/0", full, err);
    end
    replay(2, 1'b0, 200);
    n_vec++;
    if (got_w.size() != 16) begin
      n_bad++;
      $display("FAIL refill_count: got %0d need 16", got_w.size());
    end
    for (int i = 0; i < got_w.size() && i < 16; i++) begin
      n_vec++;
      if ({got_l[i], got_w[i]} !== exp_entry(i, 16)) begin
        n_bad++;
        $display("FAIL refill_word%0d: got %h need %h", i, {got_l[i], got_w[i]}, exp_entry(i, 16));
      end
    end
  endtask

  initial begin
    test_reset();
    test_layer0();
    test_layer1();
    test_backpressure();
    test_early_last();
    test_back_to_back();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
